fir_decim_sat: RTL and testbench

Downstream stage of pip_FIR. Consumes the FIR's 33-bit signed output stream, keeps one sample in every DECIM, rescales it with an arithmetic right shift (round-half-up) and saturates it to OUT_W bits. Results pass through a small first-word-fall-through FIFO with a valid/ready output handshake. Saturation and overflow-drop events are counted for debug.

---
 rtl/fir_pkg.sv | 39 +++
 rtl/fir_decim_sat_if.sv | 14 +
 rtl/fir_sync_fifo.sv | 51 +++++
 rtl/fir_decim_sat.sv | 86 ++++++++
 tb/tb_fir_decim_sat.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared widths, sample types and the round/shift/saturate helper for the
// FIR decimation stage.
package fir_pkg;

  localparam int unsigned IN_W  = 33;
  localparam int unsigned OUT_W = 16;

  typedef logic signed [IN_W-1:0]  fir_samp_t;
  typedef logic signed [OUT_W-1:0] out_samp_t;

  typedef struct packed {
    logic      sat;
    out_samp_t val;
  } sat_res_t;

  localparam logic signed [IN_W:0] R_MAX = (IN_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [IN_W:0] R_MIN = -R_MAX - 1;

  // Round-half-up arithmetic shift at IN_W+1 bits, then clip to OUT_W.
  function automatic sat_res_t sat_round(input fir_samp_t samp, input int unsigned shift);
    logic signed [IN_W:0] rnd;
    logic signed [IN_W:0] w;
    logic signed [IN_W:0] r;
    sat_res_t             res;
    rnd = '0;
    if (shift > 0) rnd = (IN_W+1)'(1) << (shift - 1);
    w = {samp[IN_W-1], samp} + rnd;
    r = w >>> shift;
    res.sat = 1'b1;
    if (r > R_MAX)      res.val = 16'h7FFF;
    else if (r < R_MIN) res.val = 16'h8000;
    else begin
      res.sat = 1'b0;
      res.val = r[OUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_decim_sat_if.sv
// Sample input and valid/ready output stream of the decimation stage.
interface fir_decim_sat_if #(
  parameter int unsigned IN_W  = fir_pkg::IN_W,
  parameter int unsigned OUT_W = fir_pkg::OUT_W
);
  logic signed [IN_W-1:0]  y_in;
  logic                    y_valid;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport master (output y_in, y_valid, out_ready, input out_data, out_valid);
  modport slave  (input y_in, y_valid, out_ready, output out_data, out_valid);
endinterface

// File: rtl/fir_sync_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry an extra wrap bit.
module fir_sync_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WIDTH      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic             do_pop, do_push;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/fir_decim_sat.sv
// Decimates the FIR output, rescales with rounding, saturates to OUT_W and
// buffers results in a small FWFT FIFO; counts saturations and drops.
module fir_decim_sat #(
  parameter int unsigned IN_W       = fir_pkg::IN_W,
  parameter int unsigned OUT_W      = fir_pkg::OUT_W,
  parameter int unsigned SHIFT      = 15,
  parameter int unsigned DECIM      = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  fir_decim_sat_if.slave     bus,
  output logic [15:0]        sat_count,
  output logic [15:0]        drop_count
);
  import fir_pkg::sat_res_t;
  import fir_pkg::fir_samp_t;
  import fir_pkg::sat_round;

  localparam int unsigned PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [PH_W-1:0]  phase_q, phase_d;
  logic             v1_q, v1_d, v2_q, v2_d;
  sat_res_t         res1_q, res1_d;
  logic [OUT_W-1:0] s_q, s_d;
  logic [15:0]      sat_count_q, sat_count_d, drop_count_q, drop_count_d;
  logic             keep, pop, fifo_empty, fifo_full;

  assign keep          = bus.y_valid && (phase_q == '0);
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_valid = !fifo_empty;
  assign sat_count     = sat_count_q;
  assign drop_count    = drop_count_q;

  // The clip decision is made with the rounding in stage 1; stage 2 only
  // registers the clipped word and bumps the saturation counter.
  always_comb begin
    phase_d      = phase_q;
    v1_d         = keep;
    res1_d       = sat_round(fir_samp_t'(bus.y_in), SHIFT);
    v2_d         = v1_q;
    s_d          = res1_q.val;
    sat_count_d  = sat_count_q;
    drop_count_d = drop_count_q;
    if (bus.y_valid)
      phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + 1'b1;
    if (v1_q && res1_q.sat && (sat_count_q != '1))
      sat_count_d = sat_count_q + 16'd1;
    if (v2_q && fifo_full && !pop && (drop_count_q != '1))
      drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q      <= '0;
      v1_q         <= 1'b0;
      res1_q       <= '0;
      v2_q         <= 1'b0;
      s_q          <= '0;
      sat_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      phase_q      <= phase_d;
      v1_q         <= v1_d;
      res1_q       <= res1_d;
      v2_q         <= v2_d;
      s_q          <= s_d;
      sat_count_q  <= sat_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  fir_sync_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (OUT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (v2_q),
    .din   (s_q),
    .pop   (pop),
    .dout  (bus.out_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );
endmodule

// File: tb/tb_fir_decim_sat.sv
// Directed and randomized bench for fir_decim_sat with DECIM=1 and DECIM=4 instances.
module tb_fir_decim_sat;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fir_decim_sat_if #(.IN_W(33), .OUT_W(16)) bus1 ();
  fir_decim_sat_if #(.IN_W(33), .OUT_W(16)) bus4 ();
  logic [15:0] sat1, drop1, sat4, drop4;

  fir_decim_sat #(.IN_W(33), .OUT_W(16), .SHIFT(15), .DECIM(1), .FIFO_DEPTH(8)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .sat_count(sat1), .drop_count(drop1));
  fir_decim_sat #(.IN_W(33), .OUT_W(16), .SHIFT(15), .DECIM(4), .FIFO_DEPTH(8)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4), .sat_count(sat4), .drop_count(drop4));

  int checks = 0;
  int failures = 0;

  typedef struct { longint val; int due; } pend_t;
  longint mq[$];
  pend_t  pend[$];
  int     m_phase, m_sat, m_drop, ecnt;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv(input int sel, input longint y, input logic v);
    if (sel == 1) begin bus1.y_in = 33'(y); bus1.y_valid = v; end
    else          begin bus4.y_in = 33'(y); bus4.y_valid = v; end
  endtask

  task automatic rdy(input int sel, input logic r);
    if (sel == 1) bus1.out_ready = r;
    else          bus4.out_ready = r;
  endtask

  function automatic logic obs_valid(input int sel);
    return (sel == 1) ? bus1.out_valid : bus4.out_valid;
  endfunction

  function automatic logic signed [15:0] obs_data(input int sel);
    return (sel == 1) ? bus1.out_data : bus4.out_data;
  endfunction

  task automatic pop_expect(input int sel, input longint exp, input string tag);
    check({tag, "_valid"}, 64'(obs_valid(sel)), 64'd1);
    check({tag, "_data"}, obs_data(sel), exp);
    rdy(sel, 1'b1);
    tick();
    rdy(sel, 1'b0);
  endtask

  // Reference: round half up of y/2^15, then clip to the signed 16-bit range.
  function automatic longint ref_val(input longint y, output logic sat);
    longint r;
    r = (y + 64'sd16384) >>> 15;
    sat = 1'b1;
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    sat = 1'b0;
    return r;
  endfunction

  task automatic model_edge(input longint y, input logic v, input logic r);
    logic   s;
    longint val;
    logic   do_pop;
    do_pop = (mq.size() > 0) && r;
    if (do_pop) void'(mq.pop_front());
    if ((pend.size() > 0) && (pend[0].due == ecnt)) begin
      if (mq.size() < 8) mq.push_back(pend[0].val);
      else m_drop++;
      void'(pend.pop_front());
    end
    if (v) begin
      if (m_phase == 0) begin
        val = ref_val(y, s);
        if (s) m_sat++;
        pend.push_back('{val, ecnt + 2});
      end
      m_phase = (m_phase + 1) % 4;
    end
    ecnt++;
  endtask

  initial begin
    longint rnd_in [5] = '{16384, 16383, -16384, -16385, 0};
    longint rnd_exp[5] = '{1, 0, 0, -1, 0};
    longint sat_in [3] = '{64'sd2147483648, -64'sd4294967296, 64'sd1073709056};
    longint sat_exp[3] = '{32767, -32768, 32767};
    logic signed [32:0] ys;
    logic vv, rr;

    drv(1, 0, 0); drv(4, 0, 0); rdy(1, 0); rdy(4, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drv(1, longint'($signed(33'($urandom()))), 1'($urandom()));
      drv(4, longint'($signed(33'($urandom()))), 1'($urandom()));
      tick();
      check("rst_valid1", 64'(bus1.out_valid), 64'd0);
      check("rst_data1", bus1.out_data, 64'sd0);
      check("rst_valid4", 64'(bus4.out_valid), 64'd0);
    end
    check("rst_sat", 64'(sat1), 64'd0);
    check("rst_drop", 64'(drop1), 64'd0);
    reset = 1'b0;
    drv(4, 0, 0);

    drv(1, 98304, 1);
    tick(); drv(1, 0, 0);
    check("lat_e1", 64'(bus1.out_valid), 64'd0);
    tick();
    check("lat_e2", 64'(bus1.out_valid), 64'd0);
    tick();
    pop_expect(1, 3, "lat_e3");
    check("lat_empty", 64'(bus1.out_valid), 64'd0);

    for (int i = 0; i < 5; i++) begin drv(1, rnd_in[i], 1); tick(); end
    drv(1, 0, 0); repeat (3) tick();
    for (int i = 0; i < 5; i++) pop_expect(1, rnd_exp[i], "round");
    check("round_empty", 64'(bus1.out_valid), 64'd0);

    for (int i = 0; i < 3; i++) begin drv(1, sat_in[i], 1); tick(); end
    drv(1, 0, 0); repeat (3) tick();
    for (int i = 0; i < 3; i++) pop_expect(1, sat_exp[i], "sat");
    check("sat_count", 64'(sat1), 64'd2);

    for (int k = 0; k < 12; k++) begin drv(4, longint'(k) * 32768, 1); tick(); end
    drv(4, 0, 0); repeat (3) tick();
    drv(4, 12 * 32768, 1); tick();
    drv(4, 0, 0); repeat (3) tick();
    for (int k = 0; k < 4; k++) pop_expect(4, longint'(k) * 4, "decim");
    check("decim_empty", 64'(bus4.out_valid), 64'd0);

    for (int v = 1; v <= 10; v++) begin drv(1, longint'(v) * 32768, 1); tick(); end
    drv(1, 0, 0); repeat (3) tick();
    check("bp_drop", 64'(drop1), 64'd2);
    for (int v = 1; v <= 8; v++) pop_expect(1, v, "bp");
    check("bp_empty", 64'(bus1.out_valid), 64'd0);

    for (int v = 1; v <= 8; v++) begin drv(1, longint'(v) * 32768, 1); tick(); end
    drv(1, 0, 0); repeat (3) tick();
    drv(1, 9 * 32768, 1); tick();
    drv(1, 0, 0); tick();
    pop_expect(1, 1, "fullpop");
    check("fullpop_drop", 64'(drop1), 64'd2);
    for (int v = 2; v <= 9; v++) pop_expect(1, v, "fullpop");
    check("fullpop_empty", 64'(bus1.out_valid), 64'd0);

    for (int v = 1; v <= 3; v++) begin drv(1, longint'(v) * 32768, 1); tick(); end
    drv(1, 0, 0); repeat (3) tick();
    pop_expect(1, 1, "middrain");
    #2 reset = 1'b1;
    #1;
    check("midrst_valid", 64'(bus1.out_valid), 64'd0);
    check("midrst_sat", 64'(sat1), 64'd0);
    check("midrst_drop", 64'(drop1), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    m_phase = 0; m_sat = 0; m_drop = 0; ecnt = 0;
    for (int c = 0; c < 830; c++) begin
      if (c < 800) begin
        ys = {1'($urandom()), 32'($urandom())};
        if ($urandom_range(0, 1) == 0) ys = 33'($signed(24'($urandom())));
        vv = ($urandom_range(0, 9) < 8);
        rr = ($urandom_range(0, 9) < ((c < 400) ? 2 : 6));
      end else begin
        ys = '0; vv = 1'b0; rr = 1'b1;
      end
      drv(4, longint'(ys), vv);
      rdy(4, rr);
      model_edge(longint'(ys), vv, rr);
      tick();
      check("rnd_valid", 64'(bus4.out_valid), 64'((mq.size() > 0) ? 1 : 0));
      if (mq.size() > 0) check("rnd_data", bus4.out_data, mq[0]);
    end
    rdy(4, 0);
    check("rnd_sat", 64'(sat4), 64'((m_sat > 65535) ? 65535 : m_sat));
    check("rnd_drop", 64'(drop4), 64'((m_drop > 65535) ? 65535 : m_drop));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
